// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int WORD_BYTES     = DATA_WIDTH_DEF / 8;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for both arbiter ports; requesters use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wd;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rd;
  logic                  rsp0_err;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wd;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rd;
  logic                  rsp1_err;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wd,
    input  req0_ready, rsp0_valid, rsp0_rd, rsp0_err,
    output req1_valid, req1_we, req1_addr, req1_wd,
    input  req1_ready, rsp1_valid, rsp1_rd, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wd,
    output req0_ready, rsp0_valid, rsp0_rd, rsp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wd,
    output req1_ready, rsp1_valid, rsp1_rd, rsp1_err
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the port that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between instruction fetch (port 0) and
// the load/store unit (port 1), one access in flight, with alignment/range checks.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_BYTES  = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  // Highest legal word address; comparing against it avoids the wrap of addr+bytes.
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ADDR_WIDTH'(MEM_BYTES - DATA_WIDTH / 8);

  state_e                state_r;
  state_e                state_nx_s;
  logic                  last_grant_r;
  logic                  port_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wd_r;
  logic [DATA_WIDTH-1:0] rd0_r;
  logic [DATA_WIDTH-1:0] rd1_r;
  logic                  err0_r;
  logic                  err1_r;
  logic [1:0]            grant_s;
  logic                  accept_s;
  logic                  err_s;
  logic [DATA_WIDTH-1:0] rsp_data_s;

  rr_arbiter2 u_rr_arbiter2 (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .last  (last_grant_r),
    .grant (grant_s)
  );

  assign accept_s   = (state_r == IDLE) && (grant_s != 2'b00);
  assign err_s      = (addr_r[1:0] != 2'b00) || (addr_r > LAST_WORD_ADDR);
  assign rsp_data_s = (we_r || err_s) ? {DATA_WIDTH{1'b0}} : mem_rd;

  assign mem_addr    = addr_r;
  assign mem_wd      = wd_r;
  assign bus.rsp0_rd  = rd0_r;
  assign bus.rsp0_err = err0_r;
  assign bus.rsp1_rd  = rd1_r;
  assign bus.rsp1_err = err1_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    state_nx_s = accept_s ? ACCESS : IDLE;
      ACCESS:  state_nx_s = RESP;
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State-decoded handshake and memory strobes
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    mem_we         = 1'b0;
    case (state_r)
      IDLE: begin
        bus.req0_ready = grant_s[0];
        bus.req1_ready = grant_s[1];
      end
      ACCESS:  mem_we = we_r && !err_s;
      RESP: begin
        bus.rsp0_valid = (port_r == PORT_IF);
        bus.rsp1_valid = (port_r == PORT_LS);
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Request latch, arbitration history and per-port response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= PORT_LS;
      port_r       <= PORT_IF;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      wd_r         <= {DATA_WIDTH{1'b0}};
      rd0_r        <= {DATA_WIDTH{1'b0}};
      rd1_r        <= {DATA_WIDTH{1'b0}};
      err0_r       <= 1'b0;
      err1_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        port_r       <= grant_s[1];
        last_grant_r <= grant_s[1];
        we_r         <= grant_s[1] ? bus.req1_we   : bus.req0_we;
        addr_r       <= grant_s[1] ? bus.req1_addr : bus.req0_addr;
        wd_r         <= grant_s[1] ? bus.req1_wd   : bus.req0_wd;
      end
      // Response data is captured at the end of ACCESS while mem_rd is addressed by addr_r.
      if (state_r == ACCESS) begin
        if (port_r == PORT_IF) begin
          rd0_r  <= rsp_data_s;
          err0_r <= err_s;
        end else begin
          rd1_r  <= rsp_data_s;
          err1_r <= err_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic        v[2];
  logic        wev[2];
  logic [31:0] addrv[2];
  logic [31:0] wdv[2];

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  assign bus.req0_valid = v[0];
  assign bus.req0_we    = wev[0];
  assign bus.req0_addr  = addrv[0];
  assign bus.req0_wd    = wdv[0];
  assign bus.req1_valid = v[1];
  assign bus.req1_we    = wev[1];
  assign bus.req1_addr  = addrv[1];
  assign bus.req1_wd    = wdv[1];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(200)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h5A5A0000 + 32'(i) * 32'h00010101);
  endfunction

  // Memory seen by the DUT: combinational read, synchronous write.
  logic [31:0] dmem[50];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 50; i++) dmem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_we && mem_addr < 32'd200) begin
      dmem[int'(mem_addr >> 2)] <= mem_wd;
    end
  end
  always_comb mem_rd = (mem_addr < 32'd200) ? dmem[int'(mem_addr >> 2)] : 32'd0;

  // Scoreboard and transaction-level model state
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          busy_until = 0;
  int          we_cyc = -1;
  int          rsp_cyc = -1;
  int          we_seen = 0;
  bit          m_last = 1'b1;
  bit          rsp_port = 1'b0;
  bit          rsp_err_q = 1'b0;
  logic [31:0] rsp_rd_q = 32'd0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wd = 32'd0;
  logic [31:0] e_rd[2];
  bit          e_err[2];
  bit          acc[2];
  logic [31:0] ref_mem[50];
  int          gq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit addr_bad(logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (longint'(a) > longint'(200 - WORD_BYTES));
  endfunction

  // One cycle: model predicts outputs from the request rules, then compares DUT.
  task automatic check_cycle();
    bit e_rdy[2];
    bit e_rv[2];
    bit e_we;
    int sel;
    @(negedge clk);
    acc[0] = 1'b0; acc[1] = 1'b0;
    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
    e_rv[0] = 1'b0; e_rv[1] = 1'b0;
    e_we = 1'b0;
    sel = -1;
    if (!rst_n) begin
      m_last = 1'b1; busy_until = cyc; we_cyc = -1; rsp_cyc = -1;
      m_addr = 32'd0; m_wd = 32'd0;
      e_rd[0] = 32'd0; e_rd[1] = 32'd0; e_err[0] = 1'b0; e_err[1] = 1'b0;
    end else begin
      if (cyc >= busy_until) begin
        if (v[0] && v[1]) sel = m_last ? 0 : 1;
        else if (v[0]) sel = 0;
        else if (v[1]) sel = 1;
      end
      if (sel >= 0) e_rdy[sel] = 1'b1;
      e_we = (cyc == we_cyc);
      if (cyc == rsp_cyc) begin
        e_rv[rsp_port]  = 1'b1;
        e_rd[rsp_port]  = rsp_rd_q;
        e_err[rsp_port] = rsp_err_q;
      end
    end
    chk("ready0", 32'(bus.req0_ready), 32'(e_rdy[0]));
    chk("ready1", 32'(bus.req1_ready), 32'(e_rdy[1]));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, m_addr);
    if (e_we) chk("mem_wd", mem_wd, m_wd);
    chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_rv[0]));
    chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_rv[1]));
    chk("rsp0_rd", bus.rsp0_rd, e_rd[0]);
    chk("rsp1_rd", bus.rsp1_rd, e_rd[1]);
    chk("rsp0_err", 32'(bus.rsp0_err), 32'(e_err[0]));
    chk("rsp1_err", 32'(bus.rsp1_err), 32'(e_err[1]));
    if (mem_we) we_seen++;
    if (rst_n && v[0] && bus.req0_ready) gq.push_back(0);
    if (rst_n && v[1] && bus.req1_ready) gq.push_back(1);
    if (rst_n) begin
      if (e_we) ref_mem[int'(m_addr >> 2)] = m_wd;
      if (sel >= 0) begin
        acc[sel]   = 1'b1;
        m_last     = sel[0];
        busy_until = cyc + 3;
        m_addr     = addrv[sel];
        m_wd       = wdv[sel];
        rsp_port   = sel[0];
        rsp_cyc    = cyc + 2;
        rsp_err_q  = addr_bad(addrv[sel]);
        rsp_rd_q   = 32'd0;
        if (!wev[sel] && !rsp_err_q) rsp_rd_q = ref_mem[int'(addrv[sel] >> 2)];
        if (wev[sel] && !rsp_err_q) we_cyc = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) if (acc[p]) v[p] = 1'b0;
  endtask

  task automatic step();
    check_cycle();
    advance();
  endtask

  task automatic req(int p, bit w, logic [31:0] a, logic [31:0] d);
    v[p] = 1'b1; wev[p] = w; addrv[p] = a; wdv[p] = d;
  endtask

  task automatic do_reset();
    v[0] = 1'b0; v[1] = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((v[0] || v[1]) && n < 40) begin
      step();
      n++;
    end
    chk("drain_done", 32'(v[0] | v[1]), 32'd0);
    repeat (3) step();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return 32'($urandom_range(0, 49)) * 32'd4;
    else if (r == 7) return 32'($urandom_range(0, 199)) | 32'd1;
    else if (r == 8) return 32'd200 + 32'd4 * 32'($urandom_range(0, 20));
    else return 32'hFFFFFFFC - 32'd4 * 32'($urandom_range(0, 3));
  endfunction

  logic [31:0] old_word;
  int          w0;

  initial begin
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; wev[p] = 1'b0; addrv[p] = 32'd0; wdv[p] = 32'd0;
      e_rd[p] = 32'd0; e_err[p] = 1'b0; acc[p] = 1'b0;
    end
    for (int i = 0; i < 50; i++) ref_mem[i] = init_word(i);
    @(posedge clk);
    #1;
    do_reset();

    // Read of a preloaded word: ready at once, response two cycles later
    req(0, 1'b0, 32'h10, 32'd0);
    #1;
    chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
    step();
    step();
    chk("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("t1_rsp0_rd", bus.rsp0_rd, 32'hDEADBEEF);
    chk("t1_rsp0_err", 32'(bus.rsp0_err), 32'd0);
    step();

    // Write from port 1 then read back on port 0
    w0 = we_seen;
    req(1, 1'b1, 32'h20, 32'h12345678);
    repeat (3) step();
    chk("t2_we_cycles", 32'(we_seen - w0), 32'd1);
    req(0, 1'b0, 32'h20, 32'd0);
    step();
    step();
    chk("t2_rsp0_rd", bus.rsp0_rd, 32'h12345678);
    step();

    // Continuous contention from reset alternates grants starting with port 0
    do_reset();
    gq.delete();
    req(0, 1'b0, 32'h08, 32'd0);
    req(1, 1'b0, 32'h0C, 32'd0);
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      step();
      if (!v[0]) req(0, 1'b0, 32'($urandom_range(0, 49)) * 32'd4, 32'd0);
      if (!v[1]) req(1, 1'b0, 32'($urandom_range(0, 49)) * 32'd4, 32'd0);
    end
    chk("t3_grant_count", 32'(gq.size()), 32'd4);
    if (gq.size() >= 4) begin
      chk("t3_grant0", 32'(gq[0]), 32'd0);
      chk("t3_grant1", 32'(gq[1]), 32'd1);
      chk("t3_grant2", 32'(gq[2]), 32'd0);
      chk("t3_grant3", 32'(gq[3]), 32'd1);
    end
    drain();

    // Misaligned and past-the-end writes are rejected; the last word is legal
    w0 = we_seen;
    req(1, 1'b1, 32'h22, 32'h11111111);
    drain();
    chk("t4_mis_err", 32'(bus.rsp1_err), 32'd1);
    chk("t4_mis_rd", bus.rsp1_rd, 32'd0);
    req(1, 1'b1, 32'hC8, 32'h22222222);
    drain();
    chk("t4_oor_err", 32'(bus.rsp1_err), 32'd1);
    chk("t4_oor_we", 32'(we_seen - w0), 32'd0);
    req(1, 1'b1, 32'hC4, 32'hA5A5C3C3);
    drain();
    chk("t4_last_err", 32'(bus.rsp1_err), 32'd0);
    chk("t4_last_we", 32'(we_seen - w0), 32'd1);

    // Reset during the ACCESS cycle of a write aborts it
    old_word = dmem[12];
    req(1, 1'b1, 32'h30, 32'hCAFEF00D);
    check_cycle();
    advance();
    chk("t5_we_access", 32'(mem_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_we_dropped", 32'(mem_we), 32'd0);
    check_cycle();
    advance();
    chk("t5_no_rsp", 32'(bus.rsp1_valid), 32'd0);
    rst_n = 1'b1;
    chk("t5_mem_kept", dmem[12], old_word);
    req(0, 1'b0, 32'h04, 32'd0);
    req(1, 1'b0, 32'h08, 32'd0);
    #1;
    chk("t5_first_grant0", 32'(bus.req0_ready), 32'd1);
    chk("t5_first_grant1", 32'(bus.req1_ready), 32'd0);
    drain();

    // Top-of-address-space read must not pass the range check
    req(0, 1'b0, 32'hFFFFFFFC, 32'd0);
    drain();
    chk("t6_high_err", 32'(bus.rsp0_err), 32'd1);
    chk("t6_high_rd", bus.rsp0_rd, 32'd0);

    // Random traffic on both ports
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && $urandom_range(0, 1) == 1)
          req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      end
      step();
    end
    drain();

    for (int i = 0; i < 50; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
